pe_grant_sched: RTL and testbench

- Downstream consumer of the reversed-prefix-OR one-hot priority encoder.
- Collects request pulses into a sticky pending register.
- Repeatedly selects the highest-index pending bit, using the same one-hot priority rule as the encoder.
- Issues each selected bit as a registered one-hot grant plus binary index over a valid/ready handshake, then retires it from pending.
- Sits between interrupt/request sources and a single serial service agent.

---
 rtl/pe_grant_sched.sv | 93 +++++++++
 tb/tb_pe_grant_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_grant_sched.sv
// MSB-priority grant scheduler: sticky pending requests are issued one at a time
// as a registered one-hot grant plus binary index over a valid/ready handshake.
module pe_grant_sched #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         flush,
  output logic         gnt_valid,
  input  logic         gnt_ready,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic [W:0]   pend_cnt,
  output logic         pend_any
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e  state_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] gnt_onehot_q;
  logic [W-1:0] gnt_idx_q;

  logic [N-1:0] sel;
  logic [W-1:0] sel_idx;
  logic         load;

  // Highest set bit wins: a bit is selected only if nothing above it is pending.
  always_comb begin
    logic seen;
    sel     = '0;
    sel_idx = '0;
    seen    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i] && !seen) begin
        sel[i]  = 1'b1;
        sel_idx = W'(i);
      end
      seen = seen | pend_q[i];
    end
  end

  assign load = (|pend_q) && ((state_q == EMPTY) || gnt_ready);

  // New requests are OR-ed in after the clear, so a same-cycle re-request survives.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = req;
    end else begin
      pend_d = (pend_q & ~(load ? sel : '0)) | req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      pend_q       <= '0;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
    end else begin
      pend_q <= pend_d;
      if (flush) begin
        state_q      <= EMPTY;
        gnt_onehot_q <= '0;
        gnt_idx_q    <= '0;
      end else if (load) begin
        state_q      <= FULL;
        gnt_onehot_q <= sel;
        gnt_idx_q    <= sel_idx;
      end else if ((state_q == FULL) && gnt_ready) begin
        state_q      <= EMPTY;
        gnt_onehot_q <= '0;
        gnt_idx_q    <= '0;
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pend_cnt = pend_cnt + (W + 1)'(pend_q[i]);
    end
  end

  assign pend_any   = |pend_q;
  assign gnt_valid  = (state_q == FULL);
  assign gnt_onehot = gnt_onehot_q;
  assign gnt_idx    = gnt_idx_q;

endmodule

// File: tb/tb_pe_grant_sched.sv
// Directed and randomized checks of pe_grant_sched against a queue-level grant model.
module tb_pe_grant_sched;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         flush;
  logic         gnt_valid;
  logic         gnt_ready;
  logic [N-1:0] gnt_onehot;
  logic [W-1:0] gnt_idx;
  logic [W:0]   pend_cnt;
  logic         pend_any;

  int checks   = 0;
  int failures = 0;

  // Reference model: set of pending lines plus the presented grant.
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_idx;

  pe_grant_sched #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .flush     (flush),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .pend_cnt  (pend_cnt),
    .pend_any  (pend_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int highest(input bit [N-1:0] p);
    for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_clock(input bit [N-1:0] r, input bit f, input bit rdy);
    bit can_load;
    can_load = (m_pend != 0) && (!m_valid || rdy);
    if (f) begin
      m_pend  = r;
      m_valid = 1'b0;
      m_idx   = 0;
    end else if (can_load) begin
      m_idx   = highest(m_pend);
      m_valid = 1'b1;
      m_pend[m_idx] = 1'b0;
      m_pend  = m_pend | r;
    end else begin
      if (m_valid && rdy) begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
      m_pend = m_pend | r;
    end
  endtask

  task automatic check_model(input string tag);
    bit [N-1:0] exp_oh;
    exp_oh = m_valid ? (N'(1) << m_idx) : '0;
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_valid));
    chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(exp_oh));
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(m_valid ? m_idx : 0));
    chk({tag, "_cnt"}, 32'(pend_cnt), 32'($countones(m_pend)));
    chk({tag, "_any"}, 32'(pend_any), 32'(m_pend != 0));
  endtask

  // Apply inputs for one cycle; outputs are compared mid-cycle before the edge.
  task automatic step(input string tag, input logic [N-1:0] r, input logic f, input logic rdy);
    req = r;
    flush = f;
    gnt_ready = rdy;
    #1;
    check_model(tag);
    @(posedge clk);
    model_clock(r, f, rdy);
    #1;
  endtask

  initial begin
    req = '0;
    flush = 1'b0;
    gnt_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    chk("reset_onehot", 32'(gnt_onehot), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_cnt", 32'(pend_cnt), 32'd0);
    chk("reset_any", 32'(pend_any), 32'd0);
    rst_n = 1'b1;

    // Two requests in one pulse: idx 5 then idx 2
    step("t1_req", 8'h24, 1'b0, 1'b1);
    chk("t1_cnt2", 32'(pend_cnt), 32'd2);
    chk("t1_novalid", 32'(gnt_valid), 32'd0);
    step("t1_a", 8'h00, 1'b0, 1'b1);
    chk("t1_idx5", 32'(gnt_idx), 32'd5);
    chk("t1_oh20", 32'(gnt_onehot), 32'h20);
    chk("t1_cnt1", 32'(pend_cnt), 32'd1);
    step("t1_b", 8'h00, 1'b0, 1'b1);
    chk("t1_idx2", 32'(gnt_idx), 32'd2);
    chk("t1_oh04", 32'(gnt_onehot), 32'h04);
    chk("t1_cnt0", 32'(pend_cnt), 32'd0);
    step("t1_c", 8'h00, 1'b0, 1'b1);
    chk("t1_empty", 32'(gnt_valid), 32'd0);

    // Backpressure: held grant ignores a new higher-priority request
    step("bp_req", 8'h01, 1'b0, 1'b0);
    step("bp_load", 8'h00, 1'b0, 1'b0);
    chk("bp_idx0", 32'(gnt_idx), 32'd0);
    chk("bp_oh01", 32'(gnt_onehot), 32'h01);
    step("bp_hi", 8'h80, 1'b0, 1'b0);
    step("bp_hold", 8'h00, 1'b0, 1'b0);
    chk("bp_held_oh", 32'(gnt_onehot), 32'h01);
    chk("bp_held_valid", 32'(gnt_valid), 32'd1);
    step("bp_accept", 8'h00, 1'b0, 1'b1);
    chk("bp_idx7", 32'(gnt_idx), 32'd7);
    step("bp_drain", 8'h00, 1'b0, 1'b1);
    chk("bp_empty", 32'(gnt_valid), 32'd0);

    // Set wins over clear on the bit being granted
    step("sw_req", 8'h80, 1'b0, 1'b1);
    step("sw_same", 8'h80, 1'b0, 1'b1);
    chk("sw_oh80", 32'(gnt_onehot), 32'h80);
    chk("sw_still_pend", 32'(pend_cnt), 32'd1);
    step("sw_second", 8'h00, 1'b0, 1'b1);
    chk("sw_idx7_again", 32'(gnt_idx), 32'd7);
    chk("sw_valid_again", 32'(gnt_valid), 32'd1);
    chk("sw_cnt0", 32'(pend_cnt), 32'd0);
    step("sw_drain", 8'h00, 1'b0, 1'b1);

    // All ones: eight back-to-back grants from idx 7 down to 0
    step("ao_req", 8'hFF, 1'b0, 1'b1);
    chk("ao_cnt8", 32'(pend_cnt), 32'd8);
    for (int k = 0; k < N; k++) begin
      step("ao_run", 8'h00, 1'b0, 1'b1);
      chk("ao_idx", 32'(gnt_idx), 32'(7 - k));
      chk("ao_onehot", 32'(gnt_onehot), 32'(8'h80 >> k));
    end
    step("ao_drain", 8'h00, 1'b0, 1'b1);
    chk("ao_empty", 32'(gnt_valid), 32'd0);

    // Flush drops the presented grant and keeps only the same-cycle request
    step("fl_a", 8'h08, 1'b0, 1'b0);
    step("fl_b", 8'h06, 1'b0, 1'b0);
    chk("fl_idx3", 32'(gnt_idx), 32'd3);
    chk("fl_cnt2", 32'(pend_cnt), 32'd2);
    step("fl_flush", 8'h10, 1'b1, 1'b1);
    chk("fl_dropped", 32'(gnt_valid), 32'd0);
    chk("fl_cnt1", 32'(pend_cnt), 32'd1);
    step("fl_next", 8'h00, 1'b0, 1'b1);
    chk("fl_idx4", 32'(gnt_idx), 32'd4);
    step("fl_drain", 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    step("ar_a", 8'h80, 1'b0, 1'b0);
    step("ar_b", 8'h5A, 1'b0, 1'b0);
    chk("ar_pre_valid", 32'(gnt_valid), 32'd1);
    chk("ar_pre_cnt", 32'(pend_cnt), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(gnt_valid), 32'd0);
    chk("ar_onehot", 32'(gnt_onehot), 32'd0);
    chk("ar_idx", 32'(gnt_idx), 32'd0);
    chk("ar_cnt", 32'(pend_cnt), 32'd0);
    chk("ar_any", 32'(pend_any), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("ar_idle1", 8'h00, 1'b0, 1'b1);
    step("ar_idle2", 8'h00, 1'b0, 1'b1);
    chk("ar_no_grant", 32'(gnt_valid), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step("rnd", r, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
    end
    step("rnd_final", 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
